// File: rtl/adder8_slice_sched.sv
// Two-requester sequencer that performs 8-bit additions on a shared 5-bit adder slice.
// Low nibble first, then high nibble with the low carry injected into both operand LSBs.
module adder8_slice_sched #(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  output logic [4:0] slice_a,
  output logic [4:0] slice_b,
  input  logic [5:0] slice_s,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [8:0] rsp_sum,
  output logic       rsp_id
);

  typedef enum logic [1:0] {StIdle, StLo, StHi, StResp} state_e;

  state_e     r_state;
  logic       r_ptr;
  logic       r_id;
  logic       r_c;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic [8:0] r_sum;

  logic w_idle;
  logic w_grant0;
  logic w_grant1;
  logic w_unused;

  // With a correct slice the HI-pass LSB is always 0 and carries no information.
  assign w_unused = slice_s[0];
  assign w_idle   = (r_state == StIdle);

  always_comb begin
    w_grant0 = req0_valid & (~req1_valid | ~RR_EN | ~r_ptr);
    w_grant1 = req1_valid & ~w_grant0;
  end

  assign req0_ready = w_idle & ~rst & w_grant0;
  assign req1_ready = w_idle & ~rst & w_grant1;

  always_comb begin
    slice_a = 5'h00;
    slice_b = 5'h00;
    case (r_state)
      StLo: begin
        slice_a = {1'b0, r_a[3:0]};
        slice_b = {1'b0, r_b[3:0]};
      end
      StHi: begin
        slice_a = {r_a[7:4], r_c};
        slice_b = {r_b[7:4], r_c};
      end
      default: ;
    endcase
  end

  assign rsp_valid = (r_state == StResp);
  assign rsp_sum   = r_sum;
  assign rsp_id    = r_id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_ptr   <= 1'b0;
      r_id    <= 1'b0;
      r_c     <= 1'b0;
      r_a     <= 8'h00;
      r_b     <= 8'h00;
      r_sum   <= 9'h000;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_grant0 | w_grant1) begin
            r_a     <= w_grant1 ? req1_a : req0_a;
            r_b     <= w_grant1 ? req1_b : req0_b;
            r_id    <= w_grant1;
            r_state <= StLo;
          end
        end
        StLo: begin
          r_sum[3:0] <= slice_s[3:0];
          r_c        <= slice_s[4];
          r_state    <= StHi;
        end
        StHi: begin
          r_sum[8:4] <= slice_s[5:1];
          r_state    <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            r_state <= StIdle;
            if (RR_EN) r_ptr <= ~r_id;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/adder8_slice_sched.md
# adder8_slice_sched

Sequencer and arbiter that shares one external 5-bit adder slice between two requesters. The slice has no carry-in and produces a 6-bit sum. The block performs full 8-bit additions in two slice passes: low nibble first, then high nibble with the carry injected. It sits between requester logic and an exact or approximate slice netlist, so slice variants can be swapped without touching requesters.

## Interface
Parameters:
- RR_EN, default 1: 1 = round-robin arbitration between requesters; 0 = fixed priority, req0 always wins.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0 operation accepted this cycle when valid & ready.
- req0_a, req0_b  in  8 each  requester 0 operands.
- req1_valid, req1_ready, req1_a, req1_b  same as req0, for requester 1.
- slice_a  out  5  slice operand A.
- slice_b  out  5  slice operand B.
- slice_s  in  6  slice sum, combinational from slice_a/slice_b within the same cycle.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_sum  out  9  8-bit sum plus carry-out.
- rsp_id  out  1  requester index of the result.

## Operation
- FSM states: IDLE, LO, HI, RESP.
- **IDLE:**
  - Grant is combinational.
  - One requester valid: it is granted.
  - Both valid: with RR_EN=1 the requester at the priority pointer wins; with RR_EN=0 req0 wins.
  - reqN_ready = grant_N, asserted only in IDLE; the other ready is 0.
  - On handshake: capture a, b and id, then go to LO.
- **LO:**
  - slice_a = {1'b0, a[3:0]}, slice_b = {1'b0, b[3:0]}.
  - Register sum[3:0] = slice_s[3:0] and carry c = slice_s[4]. Go to HI.
- **HI:**
  - slice_a = {a[7:4], c}, slice_b = {b[7:4], c}.
  - Register sum[8:4] = slice_s[5:1]; slice_s[0] is ignored and is always 0 for a correct slice. Go to RESP.
- **RESP:**
  - rsp_valid = 1; rsp_sum and rsp_id are held stable.
  - On rsp_valid & rsp_ready: go to IDLE. With RR_EN=1, set the priority pointer to ~rsp_id.
- slice_a and slice_b are driven 0 in IDLE and RESP.
- rsp_sum is passed through unmodified. An approximate slice yields an approximate sum; the block does no correction.
- Arithmetic is unsigned. The carry-out lands in rsp_sum[8].

## Timing
- Reset values: state IDLE, pointer 0, rsp_valid 0, rsp_sum 0, rsp_id 0, req0_ready 0, req1_ready 0, slice_a 0, slice_b 0.
- Both readies are forced to 0 while rst is high.
- Latency: handshake at edge T (T = the edge where valid & ready are sampled high); rsp_valid rises after edge T+2. Minimum occupancy is 4 cycles per operation (IDLE, LO, HI, RESP). With rsp_ready tied high, throughput is 1 operation per 4 cycles.
- Backpressure: RESP holds indefinitely while rsp_ready = 0, and no new request is accepted. Operands are not re-read after capture; requesters may change a/b after their handshake.
- A request that deasserts valid before handshake is simply not granted. Valid-without-ready does not need to be held stable by requesters; the block samples only at handshake.
- Reset mid-operation (LO, HI or RESP): the operation is discarded, no response is produced, and the FSM is in IDLE on the first clock after reset release.
- The pointer changes only on a response handshake, never on grant alone.

## Test plan
- Carry propagation: req0 a=8'hFF, b=8'h01, rsp_ready=1. rsp_valid is high on the third cycle after the handshake cycle, with rsp_sum=9'h100, rsp_id=0. During LO, slice_a=5'h0F, slice_b=5'h01. During HI, slice_a=5'h1F, slice_b=5'h01.
- Round-robin with RR_EN=1: both requesters continuously valid with distinct operands (req0 8'h12+8'h34, req1 8'hA0+8'h70). Grants alternate 0,1,0,1 and sums alternate 9'h046 and 9'h110. Neither requester starves over 8 operations.
- Fixed priority with RR_EN=0, same stimulus: req1_ready is never asserted and all responses have rsp_id=0.
- Backpressure: rsp_ready=0 for 10 cycles in RESP. rsp_valid, rsp_sum and rsp_id stay stable, both readies stay 0, and slice operands stay 0. Raising rsp_ready gives exactly one response, then a return to IDLE.
- Reset mid-operation: assert rst during HI. All outputs are at reset values immediately (asynchronous). After release, no response is emitted for the dropped operation, and the next request completes correctly (8'h80+8'h80 = 9'h100).
- Random: 10k random operand pairs with random valid and rsp_ready, checked against a reference adder model using an exact slice. Every accepted request yields exactly one in-order response with the correct id and sum.
